// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/MULTU/DIV/DIVU sequencer.
package muldiv_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MD_OP_MULT  = 2'b00,
        MD_OP_MULTU = 2'b01,
        MD_OP_DIV   = 2'b10,
        MD_OP_DIVU  = 2'b11
    } MulDivOpType;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } MulDivStateType;

    // Divide by zero: LO is all ones, HI takes the dividend unchanged.
    localparam logic [DATA_W-1:0] DIV0_LO = '1;

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? (~x + DATA_W'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// o_q/o_r show the quotient/remainder after the step taken this cycle.
module div_iter_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_r
);

    logic [W-1:0] r_rem;
    logic [W-1:0] r_quot;
    logic [W-1:0] r_dvs;
    logic [W:0]   w_shift;
    logic [W-1:0] w_sub;
    logic         w_fits;

    // Partial remainder is shifted left with the next dividend bit; the
    // subtraction fits in W bits whenever the trial succeeds.
    assign w_shift = {r_rem, r_quot[W-1]};
    assign w_fits  = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[W-1:0] - r_dvs;
    assign o_q     = {r_quot[W-2:0], w_fits};
    assign o_r     = w_fits ? w_sub : w_shift[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_dvs  <= '0;
        end else if (i_load) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_dvs  <= i_divisor;
        end else if (i_step) begin
            r_rem  <= o_r;
            r_quot <= o_q;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mul/div sequencer beside EXE: captures operands, stalls the
// pipeline while running and delivers HI/LO with a one-cycle write strobe.
//   state   | meaning
//   MD_IDLE | waiting for a mul/div in EXE
//   MD_MUL  | multiply pipeline draining, counter counts down
//   MD_DIV  | divider iterating, one quotient bit per cycle
//   MD_DONE | HI/LO valid, Done pulse, back to IDLE
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXE_Start,
    input  logic [1:0]  EXE_MulDivOp,
    input  logic [31:0] EXE_BusA,
    input  logic [31:0] EXE_BusB,
    input  logic        Flush,
    output logic        MulDiv_Busy,
    output logic        MulDiv_Done,
    output logic        MulDiv_HILOWr,
    output logic [31:0] MulDiv_Hi,
    output logic [31:0] MulDiv_Lo
);

    localparam int CNT_MAX = (DIV_CYCLES > MUL_LATENCY) ? DIV_CYCLES : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    MulDivStateType   r_state;
    MulDivStateType   w_state_nxt;
    MulDivOpType      w_op;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_is_div;
    logic             w_signed;
    logic             w_b_zero;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [63:0]      w_ext_a;
    logic [63:0]      w_ext_b;
    logic [63:0]      w_prod;
    logic [63:0]      r_mpipe [MUL_LATENCY];
    logic [31:0]      w_q;
    logic [31:0]      w_r;
    logic [31:0]      w_div_lo;
    logic [31:0]      w_div_hi;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    assign w_op     = MulDivOpType'(EXE_MulDivOp);
    assign w_is_div = (w_op == MD_OP_DIV) || (w_op == MD_OP_DIVU);
    assign w_signed = (w_op == MD_OP_MULT) || (w_op == MD_OP_DIV);
    assign w_b_zero = (EXE_BusB == '0);
    assign w_accept = (r_state == MD_IDLE) && EXE_Start && !Flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            MD_IDLE: begin
                if (w_accept) begin
                    if (!w_is_div)     w_state_nxt = MD_MUL;
                    else if (w_b_zero) w_state_nxt = MD_DONE;
                    else               w_state_nxt = MD_DIV;
                end
            end
            MD_MUL, MD_DIV: begin
                if (Flush)               w_state_nxt = MD_IDLE;
                else if (r_cnt == '0)    w_state_nxt = MD_DONE;
            end
            MD_DONE: w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        MulDiv_Busy   = !rst && ((r_state == MD_MUL) || (r_state == MD_DIV) || w_accept);
        MulDiv_Done   = (r_state == MD_DONE);
        MulDiv_HILOWr = MulDiv_Done && !Flush;
        MulDiv_Hi     = r_hi;
        MulDiv_Lo     = r_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_LATENCY - 1);
            r_neg_q <= w_signed && (EXE_BusA[31] ^ EXE_BusB[31]);
            r_neg_r <= w_signed && EXE_BusA[31];
        end else if (((r_state == MD_MUL) || (r_state == MD_DIV)) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Full 64-bit extension keeps the low 64 product bits exact for both signednesses.
    assign w_ext_a = {{32{w_signed & EXE_BusA[31]}}, EXE_BusA};
    assign w_ext_b = {{32{w_signed & EXE_BusB[31]}}, EXE_BusB};
    assign w_prod  = w_ext_a * w_ext_b;

    always_ff @(posedge clk) begin
        r_mpipe[0] <= w_prod;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            r_mpipe[i] <= r_mpipe[i-1];
        end
    end

    div_iter_unit #(.W(32)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept && w_is_div),
        .i_step     (r_state == MD_DIV),
        .i_dividend (w_signed ? abs_val(EXE_BusA) : EXE_BusA),
        .i_divisor  (w_signed ? abs_val(EXE_BusB) : EXE_BusB),
        .o_q        (w_q),
        .o_r        (w_r)
    );

    assign w_div_lo = r_neg_q ? (~w_q + 32'd1) : w_q;
    assign w_div_hi = r_neg_r ? (~w_r + 32'd1) : w_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((w_state_nxt == MD_DONE) && (r_state != MD_DONE)) begin
            unique case (r_state)
                MD_IDLE: {r_hi, r_lo} <= {EXE_BusA, DIV0_LO};
                MD_MUL:  {r_hi, r_lo} <= r_mpipe[MUL_LATENCY-1];
                default: {r_hi, r_lo} <= {w_div_hi, w_div_lo};
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against a transaction-level reference model.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_CYC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        EXE_Start;
    logic [1:0]  EXE_MulDivOp;
    logic [31:0] EXE_BusA;
    logic [31:0] EXE_BusB;
    logic        Flush;
    logic        MulDiv_Busy;
    logic        MulDiv_Done;
    logic        MulDiv_HILOWr;
    logic [31:0] MulDiv_Hi;
    logic [31:0] MulDiv_Lo;

    muldiv_ctrl #(.MUL_LATENCY(MUL_LAT), .DIV_CYCLES(DIV_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .EXE_Start     (EXE_Start),
        .EXE_MulDivOp  (EXE_MulDivOp),
        .EXE_BusA      (EXE_BusA),
        .EXE_BusB      (EXE_BusB),
        .Flush         (Flush),
        .MulDiv_Busy   (MulDiv_Busy),
        .MulDiv_Done   (MulDiv_Done),
        .MulDiv_HILOWr (MulDiv_HILOWr),
        .MulDiv_Hi     (MulDiv_Hi),
        .MulDiv_Lo     (MulDiv_Lo)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int errs  = 0;

    // model: one in-flight op with the cycle its Done is due
    int          cyc = 0;
    bit          m_inflight = 0;
    int          m_done_cyc = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;

    int          obs_busy, obs_dones, obs_done_off, k_cur;
    bit          obs_wr;
    logic [31:0] obs_hi, obs_lo;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'd0: return 64'($signed(longint'(sa) * longint'(sb)));
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] b);
        if (op < 2) return MUL_LAT;
        if (b == 0) return 0;
        return DIV_CYC;
    endfunction

    task automatic step_cycle(input bit st, input bit fl, input bit rs);
        bit e_busy, e_done, e_wr;
        EXE_Start = st;
        Flush     = fl;
        rst       = rs;
        #1;
        if (m_inflight && cyc == m_done_cyc) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
        end
        e_done = m_inflight && (cyc == m_done_cyc);
        e_busy = !rs && ((m_inflight && cyc < m_done_cyc) || (!m_inflight && st && !fl));
        e_wr   = e_done && !fl;
        chk("busy",   64'(MulDiv_Busy),   64'(e_busy));
        chk("done",   64'(MulDiv_Done),   64'(e_done));
        chk("hilowr", 64'(MulDiv_HILOWr), 64'(e_wr));
        chk("hi",     64'(MulDiv_Hi),     64'(m_hi));
        chk("lo",     64'(MulDiv_Lo),     64'(m_lo));
        if (MulDiv_Busy) obs_busy++;
        if (MulDiv_Done) begin
            obs_dones++;
            obs_done_off = k_cur;
            obs_hi = MulDiv_Hi;
            obs_lo = MulDiv_Lo;
            obs_wr = MulDiv_HILOWr;
        end
        if (rs) begin
            m_inflight = 0;
            m_hi = '0;
            m_lo = '0;
        end else if (m_inflight) begin
            if (cyc == m_done_cyc || fl) m_inflight = 0;
        end else if (st && !fl) begin
            {m_pend_hi, m_pend_lo} = ref_result(EXE_MulDivOp, EXE_BusA, EXE_BusB);
            m_done_cyc = cyc + 1 + latency(EXE_MulDivOp, EXE_BusB);
            m_inflight = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Start is held for the whole op, including its DONE cycle; the bus is
    // scrambled after the first cycle so only latched operands may matter.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int rst_at);
        int k;
        k = 0;
        EXE_MulDivOp = op;
        EXE_BusA = a;
        EXE_BusB = b;
        obs_busy = 0;
        obs_dones = 0;
        obs_done_off = -1;
        obs_wr = 0;
        do begin
            k_cur = k;
            step_cycle(1'b1, k == flush_at, k == rst_at);
            EXE_MulDivOp = 2'($urandom_range(0, 3));
            EXE_BusA = $urandom;
            EXE_BusB = $urandom;
            k++;
        end while (m_inflight && k < 60);
        if (k >= 60) chk("op_timeout", 64'(k), 64'(59));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        EXE_Start = 1'b0;
        Flush = 1'b0;
        EXE_MulDivOp = 2'd0;
        EXE_BusA = '0;
        EXE_BusB = '0;
        repeat (2) @(posedge clk);
        #1;

        chk("ref_div_neg", ref_result(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_mult",    ref_result(2'd0, 32'hFFFF_FFFF, 32'd2), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("ref_multu",   ref_result(2'd1, 32'hFFFF_FFFF, 32'd2), 64'h0000_0001_FFFF_FFFE);

        step_cycle(1'b0, 1'b0, 1'b1);
        step_cycle(1'b0, 1'b0, 1'b0);

        issue(2'd3, 32'd100, 32'd7, -1, -1);
        chk("t1_lo", 64'(obs_lo), 64'd14);
        chk("t1_hi", 64'(obs_hi), 64'd2);
        chk("t1_busy_cycles", 64'(obs_busy), 64'd33);
        chk("t1_done_off", 64'(obs_done_off), 64'd33);
        chk("t1_wr", 64'(obs_wr), 64'd1);
        step_cycle(1'b0, 1'b0, 1'b0);

        issue(2'd2, 32'hFFFF_FFF9, 32'd2, -1, -1);
        chk("t2_lo", 64'(obs_lo), 64'hFFFF_FFFD);
        chk("t2_hi", 64'(obs_hi), 64'hFFFF_FFFF);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        chk("t2_min_lo", 64'(obs_lo), 64'h8000_0000);
        chk("t2_min_hi", 64'(obs_hi), 64'd0);

        issue(2'd0, 32'hFFFF_FFFF, 32'd2, -1, -1);
        chk("t3_mult_hi", 64'(obs_hi), 64'hFFFF_FFFF);
        chk("t3_mult_lo", 64'(obs_lo), 64'hFFFF_FFFE);
        chk("t3_done_off", 64'(obs_done_off), 64'd3);
        issue(2'd1, 32'hFFFF_FFFF, 32'd2, -1, -1);
        chk("t3_multu_hi", 64'(obs_hi), 64'd1);
        chk("t3_multu_lo", 64'(obs_lo), 64'hFFFF_FFFE);

        issue(2'd2, 32'd1000, 32'd3, 10, -1);
        chk("t4_no_done", 64'(obs_dones), 64'd0);
        chk("t4_busy_cycles", 64'(obs_busy), 64'd11);
        chk("t4_hi_kept", 64'(MulDiv_Hi), 64'd1);
        chk("t4_lo_kept", 64'(MulDiv_Lo), 64'hFFFF_FFFE);
        step_cycle(1'b0, 1'b0, 1'b0);

        issue(2'd3, 32'd5, 32'd0, 1, -1);
        chk("t5_done_off", 64'(obs_done_off), 64'd1);
        chk("t5_wr_flushed", 64'(obs_wr), 64'd0);
        chk("t5_hi", 64'(obs_hi), 64'd5);
        chk("t5_lo", 64'(obs_lo), 64'hFFFF_FFFF);

        issue(2'd1, 32'd3, 32'd4, -1, -1);
        chk("t6_first_dones", 64'(obs_dones), 64'd1);
        issue(2'd3, 32'd9, 32'd2, -1, -1);
        chk("t6_second_lo", 64'(obs_lo), 64'd4);
        chk("t6_second_hi", 64'(obs_hi), 64'd1);
        issue(2'd2, 32'd123, 32'd5, -1, 5);
        EXE_Start = 1'b0;
        Flush = 1'b0;
        #1;
        chk("t6_rst_busy", 64'(MulDiv_Busy), 64'd0);
        chk("t6_rst_done", 64'(MulDiv_Done), 64'd0);
        chk("t6_rst_hi", 64'(MulDiv_Hi), 64'd0);
        chk("t6_rst_lo", 64'(MulDiv_Lo), 64'd0);

        for (int n = 0; n < 80; n++) begin
            int fa, ra;
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 35)) : -1;
            ra = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 35)) : -1;
            issue(2'($urandom_range(0, 3)), pick(), pick(), fa, ra);
            repeat ($urandom_range(0, 2)) step_cycle(1'b0, $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
